// File: rtl/md_cell_pkg.sv
// Shared types and cell-memory layout constants for the per-cell particle fetch path.
package md_cell_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CNT,
    ST_WAIT_CNT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  localparam int CELL_RD_LATENCY = 2;
  // Word 0 of a cell holds the particle count in its low ADDR_WIDTH bits.
  localparam int CELL_CNT_ADDR   = 0;
  localparam int CELL_CNT_LSB    = 0;

endpackage

// File: rtl/cell_fetch_fifo.sv
// First-word-fall-through FIFO; occupancy is exported so the reader can issue on credits.
module cell_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Head is forced to zero when empty so stale entries never show on the port.
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/cell_particle_fetch.sv
// Reads a cell's particle count, then streams particles 1..count through a credit-checked FIFO.
// Optional count clamp and overflow flag: define CELL_COUNT_CLAMP_EN.
module cell_particle_fetch
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rden,
  output logic                  o_mem_wren,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_q,
  output logic [DATA_WIDTH-1:0] o_out_pos,
  output logic [ADDR_WIDTH-1:0] o_out_index,
  output logic                  o_out_last,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_count_err
);

  localparam int L  = CELL_RD_LATENCY;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("cell_particle_fetch: unsupported parameter combination");
  end

  fetch_state_e r_state, w_state_nxt;

  // Stage 0 is the registered read enable; stage L marks mem_q valid this cycle.
  logic [L:0]                 r_vld_pipe;
  logic [L:0][ADDR_WIDTH-1:0] r_addr_pipe;
  logic [ADDR_WIDTH-1:0]      r_count, r_next_addr;
  logic [ADDR_WIDTH-1:0]      w_cnt_raw, w_cnt, w_addr_nxt;
  logic                       w_cnt_vld, w_issue, w_rden_nxt;
  logic                       w_push, w_pop, w_last_xfer, w_fifo_empty;
  logic [CW-1:0]              w_fifo_cnt;
  logic [CW:0]                w_inflight, w_credit;
  logic [FW-1:0]              w_fifo_wdata, w_fifo_rdata;

  assign w_cnt_raw = i_mem_q[CELL_CNT_LSB +: ADDR_WIDTH];

`ifdef CELL_COUNT_CLAMP_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);
  logic w_cnt_ovf;
  logic r_count_err;
  assign w_cnt_ovf = (w_cnt_raw > MAX_IDX);
  assign w_cnt     = w_cnt_ovf ? MAX_IDX : w_cnt_raw;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                          r_count_err <= 1'b0;
    else if (r_state == ST_IDLE && i_start) r_count_err <= 1'b0;
    else if (w_cnt_vld && w_cnt_ovf)        r_count_err <= 1'b1;
  end
  assign o_count_err = r_count_err;
`else
  assign w_cnt       = w_cnt_raw;
  assign o_count_err = 1'b0;
`endif

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= L; i++) w_inflight = w_inflight + (CW+1)'(r_vld_pipe[i]);
  end

  // Everything outstanding must still fit if the consumer stops right after this pop.
  assign w_credit  = (CW+1)'(w_fifo_cnt) + w_inflight - (CW+1)'(w_pop);
  assign w_cnt_vld = (r_state == ST_WAIT_CNT) && r_vld_pipe[L];
  assign w_issue   = (w_cnt_vld && w_cnt != '0) ||
                     (r_state == ST_STREAM && w_credit < (CW+1)'(FIFO_DEPTH));
  assign w_rden_nxt = w_issue || (r_state == ST_IDLE && i_start);

  assign w_pop       = o_out_valid && i_out_ready;
  assign w_last_xfer = w_pop && o_out_last;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr_pipe[0];
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_state_nxt = ST_RD_CNT;
        w_addr_nxt  = ADDR_WIDTH'(CELL_CNT_ADDR);
      end
      ST_RD_CNT:   w_state_nxt = ST_WAIT_CNT;
      ST_WAIT_CNT: if (w_cnt_vld) begin
        if (w_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_addr_nxt  = ADDR_WIDTH'(1);
          w_state_nxt = (w_cnt == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: if (w_issue) begin
        w_addr_nxt = r_next_addr;
        if (r_next_addr == r_count) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_last_xfer && w_inflight == '0 && w_fifo_cnt == CW'(1))
        w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
      r_count     <= '0;
      r_next_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vld_pipe  <= {r_vld_pipe[L-1:0], w_rden_nxt};
      r_addr_pipe <= {r_addr_pipe[L-1:0], w_addr_nxt};
      if (w_cnt_vld) begin
        r_count     <= w_cnt;
        r_next_addr <= ADDR_WIDTH'(2);
      end else if (r_state == ST_STREAM && w_issue) begin
        r_next_addr <= r_next_addr + 1'b1;
      end
    end
  end

  // The count word also travels the pipe; only particle returns are pushed.
  assign w_push       = r_vld_pipe[L] && (r_state == ST_STREAM || r_state == ST_DRAIN);
  assign w_fifo_wdata = {(r_addr_pipe[L] == r_count), r_addr_pipe[L], i_mem_q};

  cell_fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  assign {o_out_last, o_out_index, o_out_pos} = w_fifo_rdata;
  assign o_out_valid = !w_fifo_empty;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_mem_addr  = r_addr_pipe[0];
  assign o_mem_rden  = r_vld_pipe[0];
  assign o_mem_wren  = 1'b0;
  assign o_mem_data  = '0;

endmodule

// File: tb/tb_cell_particle_fetch.sv
// Scoreboard bench for cell_particle_fetch with a 2-cycle-latency cell memory model.
module tb_cell_particle_fetch;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_out_ready;
  logic [DW-1:0] i_mem_q;
  logic          o_busy, o_done, o_mem_rden, o_mem_wren, o_out_last, o_out_valid, o_count_err;
  logic [AW-1:0] o_mem_addr, o_out_index;
  logic [DW-1:0] o_mem_data, o_out_pos;

  int cyc = 0, s0 = 0, n_chk = 0, n_fail = 0;
  int issued = 0, xfers = 0, iss_base = 0, xf_base = 0;
  bit rnd_ready = 1'b0;

  logic [DW-1:0] tb_mem [256];
  logic [DW-1:0] m_s1 = '0, m_q = '0;

  typedef struct {
    logic [DW-1:0] pos;
    logic [AW-1:0] idx;
    logic          last;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  cell_particle_fetch dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rden  (o_mem_rden),
    .o_mem_wren  (o_mem_wren),
    .o_mem_data  (o_mem_data),
    .i_mem_q     (i_mem_q),
    .o_out_pos   (o_out_pos),
    .o_out_index (o_out_index),
    .o_out_last  (o_out_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_count_err (o_count_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    m_s1 <= o_mem_rden ? tb_mem[o_mem_addr] : '0;
    m_q  <= m_s1;
  end
  assign i_mem_q = m_q;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pos_of(input int idx, input int seed);
    return {32'(seed), 32'(idx * 7 + 3), 32'h1000_0000 + 32'(idx)};
  endfunction

  function automatic logic [255:0] all_outs();
    return 256'({o_busy, o_done, o_mem_rden, o_mem_addr, o_mem_wren, o_mem_data,
                 o_out_valid, o_out_last, o_out_index, o_out_pos, o_count_err});
  endfunction

  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold-while-stalled and credit bound.
  initial begin
    exp_t e;
    bit p_hold;
    logic [DW+AW:0] p_word;
    p_hold = 1'b0;
    p_word = '0;
    forever begin
      @(negedge clk);
      if (p_hold)
        chk("hold_stable", 256'({o_out_valid, o_out_last, o_out_index, o_out_pos}),
            256'({1'b1, p_word}));
      p_hold = o_out_valid && !i_out_ready;
      p_word = {o_out_last, o_out_index, o_out_pos};
      if (o_mem_rden && o_mem_addr != '0) issued++;
      if (o_out_valid && i_out_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          chk("unexpected_xfer", 256'({1'b1, o_out_index}), 256'(0));
        end else begin
          e = sb.pop_front();
          chk("xfer_word", 256'({o_out_last, o_out_index, o_out_pos}),
              256'({e.last, e.idx, e.pos}));
          if (e.cyc >= 0) chk("xfer_cycle", 256'(cyc - s0), 256'(e.cyc));
        end
      end
      if (o_mem_rden && o_mem_addr != '0)
        chk("credit_bound", 256'(((issued - iss_base) - (xfers - xf_base)) <= FD), 256'(1));
    end
  end

  task automatic load_cell(input int cnt, input int seed);
    tb_mem[0] = 96'(cnt);
    for (int i = 1; i < 256; i++) tb_mem[i] = pos_of(i, seed);
  endtask

  task automatic push_exp(input int seed, input int nexp, input int upto, input bit timed);
    for (int i = 1; i <= upto; i++) begin
      exp_t e;
      e.pos  = pos_of(i, seed);
      e.idx  = AW'(i);
      e.last = (i == nexp);
      e.cyc  = timed ? 6 + i : -1;
      sb.push_back(e);
    end
  endtask

  task automatic issue_start();
    @(posedge clk); #1;
    s0 = cyc; iss_base = issued; xf_base = xfers;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_fetch(input int cnt, input int seed, input int nexp,
                           input bit timed, input bit exp_err, input bit poke);
    bit seen;
    load_cell(cnt, seed);
    push_exp(seed, nexp, nexp, timed);
    issue_start();
    @(negedge clk);
    chk("cnt_read", 256'({o_busy, o_mem_rden, o_mem_addr}), 256'({1'b1, 1'b1, 8'h00}));
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (poke) i_start = (cyc - s0 == 6);
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0;
    chk("done_seen", 256'(seen), 256'(1));
    if (seen && timed) chk("done_cycle", 256'(cyc - s0), 256'(nexp == 0 ? 4 : 7 + nexp));
    chk("count_err", 256'(o_count_err), 256'(exp_err));
    chk("sb_drained", 256'(sb.size()), 256'(0));
    @(negedge clk);
    chk("idle_after", 256'({o_busy, o_done, o_out_valid}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 256'(0));
    i_rst_n = 1'b1;

    run_fetch(5, 1, 5, 1'b1, 1'b0, 1'b0);
    run_fetch(0, 2, 0, 1'b1, 1'b0, 1'b0);

    rnd_ready = 1'b1;
    run_fetch(20, 3, 20, 1'b0, 1'b0, 1'b0);
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);

    run_fetch(5, 4, 5, 1'b1, 1'b0, 1'b1);
    run_fetch(3, 6, 3, 1'b1, 1'b0, 1'b0);

    // Reset lands at cycle 9 of a count-10 fetch: particles 1..3 have handshaken by then.
    load_cell(10, 5);
    push_exp(5, 10, 3, 1'b1);
    issue_start();
    repeat (8) @(posedge clk);
    #1 i_rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_outputs", all_outs(), 256'(0));
    i_rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("reset_sb_drained", 256'(sb.size()), 256'(0));
    run_fetch(4, 7, 4, 1'b1, 1'b0, 1'b0);

`ifdef CELL_COUNT_CLAMP_EN
    run_fetch(250, 8, 219, 1'b1, 1'b1, 1'b0);
`else
    run_fetch(250, 8, 250, 1'b1, 1'b0, 1'b0);
`endif
    run_fetch(1, 9, 1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
